// File: rtl/vga_grid_renderer.sv
// ============================================================================
// Module   : vga_grid_renderer
// Purpose  : VGA timing plus tile-map renderer with a robot overlay and grid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_grid_renderer #(
    parameter int GRID_COLS = 20,
    parameter int GRID_ROWS = 10,
    parameter int CELL_W    = 32,
    parameter int CELL_H    = 48,
    parameter int H_VIS     = 640,
    parameter int H_FP      = 16,
    parameter int H_SP      = 96,
    parameter int H_BP      = 48,
    parameter int V_VIS     = 480,
    parameter int V_FP      = 10,
    parameter int V_SP      = 2,
    parameter int V_BP      = 33,
    parameter int MARK      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [2:0] wr_code,
    input  logic [4:0] xr,
    input  logic [3:0] yr,
    input  logic [1:0] dr,
    input  logic       grid_en,
    output logic       h_sync,
    output logic       v_sync,
    output logic       blank,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       busy,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SP + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SP + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int COLW    = $clog2(H_TOTAL / CELL_W + GRID_COLS + 1);
    localparam int ROWW    = $clog2(V_TOTAL / CELL_H + GRID_ROWS + 1);
    localparam int PXW     = $clog2(CELL_W + 1);
    localparam int PYW     = $clog2(CELL_H + 1);
    localparam int MAP_N   = GRID_COLS * GRID_ROWS;
    localparam int MW      = $clog2(MAP_N);

    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic [COLW-1:0] r_col;
    logic [ROWW-1:0] r_row;
    logic [PXW-1:0]  r_px;
    logic [PYW-1:0]  r_py;

    logic            r_busy;
    logic [MW-1:0]   r_clr_idx;
    logic [2:0]      r_map [MAP_N];

    logic [4:0]      r_rob_x;
    logic [3:0]      r_rob_y;
    logic [1:0]      r_rob_d;

    logic            r_s1_vis;
    logic            r_s1_in_grid;
    logic            r_s1_border;
    logic            r_s1_robot;
    logic            r_s1_mark;
    logic [2:0]      r_s1_code;
    logic            r_s1_hs;
    logic            r_s1_vs;
    logic            r_s1_fs;

    logic            r_h_sync;
    logic            r_v_sync;
    logic            r_blank;
    logic            r_frame_start;
    logic [23:0]     r_rgb;

    logic            w_h_last;
    logic            w_v_last;
    logic            w_fs_raw;
    logic            w_hs_raw;
    logic            w_vs_raw;
    logic            w_vis_raw;
    logic            w_in_grid;
    logic            w_border;
    logic [4:0]      w_rob_x;
    logic [3:0]      w_rob_y;
    logic [1:0]      w_rob_d;
    logic            w_rob_hit;
    logic            w_mark;
    logic [MW-1:0]   w_rd_idx;
    logic [MW-1:0]   w_wr_idx;
    logic            w_wr_ok;
    logic [2:0]      w_code;
    logic [23:0]     w_rgb;

    // ------------------------------------------------------------------
    // Raster counters; cell column/row and in-cell offsets track alongside
    // ------------------------------------------------------------------
    assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_px    <= '0;
            r_py    <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_px    <= '0;
            r_col   <= '0;
            if (w_v_last) begin
                r_v_cnt <= '0;
                r_py    <= '0;
                r_row   <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + VW'(1);
                if (r_py == PYW'(CELL_H - 1)) begin
                    r_py  <= '0;
                    r_row <= r_row + ROWW'(1);
                end else begin
                    r_py  <= r_py + PYW'(1);
                end
            end
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
            if (r_px == PXW'(CELL_W - 1)) begin
                r_px  <= '0;
                r_col <= r_col + COLW'(1);
            end else begin
                r_px  <= r_px + PXW'(1);
            end
        end
    end

    assign w_fs_raw  = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_hs_raw  = !((r_h_cnt >= HW'(H_VIS + H_FP)) && (r_h_cnt < HW'(H_VIS + H_FP + H_SP)));
    assign w_vs_raw  = !((r_v_cnt >= VW'(V_VIS + V_FP)) && (r_v_cnt < VW'(V_VIS + V_FP + V_SP)));
    assign w_vis_raw = (r_h_cnt < HW'(H_VIS)) && (r_v_cnt < VW'(V_VIS));
    assign w_in_grid = (int'(r_col) < GRID_COLS) && (int'(r_row) < GRID_ROWS);

    // ------------------------------------------------------------------
    // Map clear sequencer and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b1;
            r_clr_idx <= '0;
        end else if (r_busy) begin
            if (r_clr_idx == MW'(MAP_N - 1)) begin
                r_busy <= 1'b0;
            end
            r_clr_idx <= r_clr_idx + MW'(1);
        end
    end

    assign w_wr_ok  = wr_en && !r_busy &&
                      (int'(wr_x) < GRID_COLS) && (int'(wr_y) < GRID_ROWS);
    assign w_wr_idx = MW'(wr_y) * MW'(GRID_COLS) + MW'(wr_x);
    assign w_rd_idx = MW'(r_row) * MW'(GRID_COLS) + MW'(r_col);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_busy) begin
                r_map[r_clr_idx] <= 3'd0;
            end else if (w_wr_ok) begin
                r_map[w_wr_idx] <= wr_code;
            end
        end
    end

    // Read before the write lands, so a same-cycle write shows next cycle
    assign w_code = w_in_grid ? r_map[w_rd_idx] : 3'd0;

    // ------------------------------------------------------------------
    // Robot pose snapshot; bypass lets pixel (0,0) see the fresh sample
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rob_x <= 5'h1F;
            r_rob_y <= 4'hF;
            r_rob_d <= 2'd0;
        end else if (w_fs_raw) begin
            r_rob_x <= xr;
            r_rob_y <= yr;
            r_rob_d <= dr;
        end
    end

    assign w_rob_x   = w_fs_raw ? xr : r_rob_x;
    assign w_rob_y   = w_fs_raw ? yr : r_rob_y;
    assign w_rob_d   = w_fs_raw ? dr : r_rob_d;
    assign w_rob_hit = (int'(w_rob_x) < GRID_COLS) && (int'(w_rob_y) < GRID_ROWS) &&
                       (int'(r_col) == int'(w_rob_x)) && (int'(r_row) == int'(w_rob_y));
    assign w_border  = grid_en && ((r_px == '0) || (r_py == '0));

    always_comb begin
        w_mark = 1'b0;
        case (w_rob_d)
            2'd0:    w_mark = int'(r_py) <  MARK;
            2'd1:    w_mark = int'(r_px) <  MARK;
            2'd2:    w_mark = int'(r_py) >= CELL_H - MARK;
            default: w_mark = int'(r_px) >= CELL_W - MARK;
        endcase
    end

    // ------------------------------------------------------------------
    // Two-stage pixel pipeline: classify, then colour
    // ------------------------------------------------------------------
    always_comb begin
        w_rgb = 24'h000000;
        if (r_s1_vis && r_s1_in_grid) begin
            if (r_s1_border) begin
                w_rgb = 24'h808080;
            end else if (r_s1_robot) begin
                w_rgb = r_s1_mark ? 24'h006400 : 24'h00FF00;
            end else begin
                case (r_s1_code)
                    3'd0:    w_rgb = 24'hFFFFFF;
                    3'd1:    w_rgb = 24'h808080;
                    3'd2:    w_rgb = 24'h000000;
                    3'd3:    w_rgb = 24'hFFFF00;
                    3'd4:    w_rgb = 24'hFFA500;
                    3'd5:    w_rgb = 24'hFF0000;
                    default: w_rgb = 24'hFF00FF;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vis      <= 1'b0;
            r_s1_in_grid  <= 1'b0;
            r_s1_border   <= 1'b0;
            r_s1_robot    <= 1'b0;
            r_s1_mark     <= 1'b0;
            r_s1_code     <= 3'd0;
            r_s1_hs       <= 1'b1;
            r_s1_vs       <= 1'b1;
            r_s1_fs       <= 1'b0;
            r_h_sync      <= 1'b1;
            r_v_sync      <= 1'b1;
            r_blank       <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= 24'h000000;
        end else begin
            r_s1_vis      <= w_vis_raw;
            r_s1_in_grid  <= w_in_grid;
            r_s1_border   <= w_border;
            r_s1_robot    <= w_rob_hit;
            r_s1_mark     <= w_mark;
            r_s1_code     <= w_code;
            r_s1_hs       <= w_hs_raw;
            r_s1_vs       <= w_vs_raw;
            r_s1_fs       <= w_fs_raw;
            r_h_sync      <= r_s1_hs;
            r_v_sync      <= r_s1_vs;
            r_blank       <= r_s1_vis;
            r_frame_start <= r_s1_fs;
            r_rgb         <= w_rgb;
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign R           = r_rgb[23:16];
    assign G           = r_rgb[15:8];
    assign B           = r_rgb[7:0];
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vga_grid_renderer.sv
// ============================================================================
// Module   : tb_vga_grid_renderer
// Purpose  : Pixel-accurate reference-model bench for vga_grid_renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_grid_renderer;

    localparam int GC = 5,  GR = 3,  CW = 8,  CH = 6,  MK = 2;
    localparam int HV = 48, HF = 4,  HS = 6,  HB = 4;
    localparam int VV = 22, VF = 2,  VS = 2,  VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int NCELL = GC * GR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_x = 5'd0;
    logic [3:0] wr_y = 4'd0;
    logic [2:0] wr_code = 3'd0;
    logic [4:0] xr = 5'd31;
    logic [3:0] yr = 4'd15;
    logic [1:0] dr = 2'd0;
    logic       grid_en = 1'b0;
    logic       h_sync, v_sync, blank, busy, frame_start;
    logic [7:0] R, G, B;

    vga_grid_renderer #(
        .GRID_COLS(GC), .GRID_ROWS(GR), .CELL_W(CW), .CELL_H(CH),
        .H_VIS(HV), .H_FP(HF), .H_SP(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SP(VS), .V_BP(VB), .MARK(MK)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_code(wr_code), .xr(xr), .yr(yr), .dr(dr), .grid_en(grid_en),
        .h_sync(h_sync), .v_sync(v_sync), .blank(blank), .R(R), .G(G), .B(B),
        .busy(busy), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int eff;
        int idx;
        int code;
    } pend_t;

    int    n_cmp = 0;
    int    n_err = 0;
    int    t = 0;
    int    mm [NCELL];
    pend_t pq [$];
    bit    ge_log [4];
    int    rcx, rcy, rcd, rpx, rpy, rpd, rob_frame;

    function automatic int colour(input int code);
        case (code)
            0: return 32'hFFFFFF;
            1: return 32'h808080;
            2: return 32'h000000;
            3: return 32'hFFFF00;
            4: return 32'hFFA500;
            5: return 32'hFF0000;
            default: return 32'hFF00FF;
        endcase
    endfunction

    task automatic model_reset();
        pend_t e;
        pq.delete();
        for (int i = 0; i < NCELL; i++) begin
            mm[i]  = 8;
            e.eff  = NCELL;
            e.idx  = i;
            e.code = 0;
            pq.push_back(e);
        end
        rcx = 31; rcy = 15; rcd = 0;
        rpx = 31; rpy = 15; rpd = 0;
        rob_frame = -1;
        t = 0;
    endtask

    task automatic check_outputs();
        int p, h, v, cx, cy, ox, oy, rx, ry, rd, rgb;
        bit known, mark;
        logic [27:0] expv, got;
        p = t - 2;
        h = 0; v = 0;
        known = 1'b1;
        n_cmp++;
        assert (busy === (t < NCELL)) else begin
            n_err++;
            $error("FAIL busy t=%0d observed=%b expected=%b", t, busy, (t < NCELL));
        end
        if (p < 0) begin
            expv = {4'b1100, 24'h000000};
        end else begin
            while (pq.size() > 0 && pq[0].eff <= p) begin
                mm[pq[0].idx] = pq[0].code;
                void'(pq.pop_front());
            end
            h = p % HT;
            v = (p / HT) % VT;
            rgb = 0;
            if (h < HV && v < VV && h < GC * CW && v < GR * CH) begin
                cx = h / CW; cy = v / CH; ox = h % CW; oy = v % CH;
                if ((p / FR) == rob_frame) begin
                    rx = rcx; ry = rcy; rd = rcd;
                end else begin
                    rx = rpx; ry = rpy; rd = rpd;
                end
                if (ge_log[p & 3] && (ox == 0 || oy == 0)) begin
                    rgb = 32'h808080;
                end else if (rx < GC && ry < GR && cx == rx && cy == ry) begin
                    case (rd)
                        0: mark = (oy < MK);
                        1: mark = (ox < MK);
                        2: mark = (oy >= CH - MK);
                        default: mark = (ox >= CW - MK);
                    endcase
                    rgb = mark ? 32'h006400 : 32'h00FF00;
                end else if (mm[cy * GC + cx] > 7) begin
                    known = 1'b0;
                end else begin
                    rgb = colour(mm[cy * GC + cx]);
                end
            end
            expv = {!(h >= HV + HF && h < HV + HF + HS),
                    !(v >= VV + VF && v < VV + VF + VS),
                    (h < HV && v < VV),
                    (h == 0 && v == 0),
                    rgb[23:0]};
        end
        got = {h_sync, v_sync, blank, frame_start, R, G, B};
        if (!known) begin
            got[23:0]  = 24'h0;
            expv[23:0] = 24'h0;
        end
        n_cmp++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL pixel t=%0d h=%0d v=%0d observed=%h expected=%h", t, h, v, got, expv);
        end
    endtask

    // Inputs for the current interval must already be driven
    task automatic tick();
        pend_t e;
        ge_log[t & 3] = grid_en;
        if (t % FR == 0) begin
            rpx = rcx; rpy = rcy; rpd = rcd;
            rcx = int'(xr); rcy = int'(yr); rcd = int'(dr);
            rob_frame = t / FR;
        end
        if (wr_en && t >= NCELL && int'(wr_x) < GC && int'(wr_y) < GR) begin
            e.eff  = t + 1;
            e.idx  = int'(wr_y) * GC + int'(wr_x);
            e.code = int'(wr_code);
            pq.push_back(e);
        end
        check_outputs();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            assert ({h_sync, v_sync, blank, frame_start, R, G, B} === {4'b1100, 24'h0}) else begin
                n_err++;
                $error("FAIL reset_out observed=%h expected=%h",
                       {h_sync, v_sync, blank, frame_start, R, G, B}, {4'b1100, 24'h0});
            end
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_cell(input int x, input int y, input int code);
        wr_en   = 1'b1;
        wr_x    = 5'(x);
        wr_y    = 4'(y);
        wr_code = 3'(code);
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int bc;
        do_reset(3);

        // Clear length, with writes attempted on the last busy cycles and the first free one
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b0;
            if (t == 5)  begin wr_en = 1'b1; wr_x = 5'd1; wr_y = 4'd1; wr_code = 3'd3; end
            if (t == 14) begin wr_en = 1'b1; wr_x = 5'd2; wr_y = 4'd1; wr_code = 3'd4; end
            if (t == 15) begin wr_en = 1'b1; wr_x = 5'd0; wr_y = 4'd0; wr_code = 3'd2; end
            if (busy) bc++;
            tick();
        end
        wr_en = 1'b0;
        n_cmp++;
        assert (bc === NCELL) else begin
            n_err++;
            $error("FAIL busy_len observed=%0d expected=%0d", bc, NCELL);
        end
        run(2 * FR - 20);

        write_cell(3, 2, 5);
        write_cell(25, 2, 4);
        write_cell(1, 7, 6);
        run(FR / 2);

        xr = 5'd4; yr = 4'd1; dr = 2'd3;
        run(FR);
        dr = 2'd0; xr = 5'd0; yr = 4'd0;
        run(FR);

        grid_en = 1'b1;
        run(FR);

        for (int i = 0; i < 3 * FR; i++) begin
            wr_en = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                wr_en   = 1'b1;
                wr_x    = 5'($urandom_range(0, 6));
                wr_y    = 4'($urandom_range(0, 3));
                wr_code = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 299) == 0) begin
                xr = 5'($urandom_range(0, 6));
                yr = 4'($urandom_range(0, 3));
                dr = 2'($urandom);
            end
            if ($urandom_range(0, 999) == 0) grid_en = ~grid_en;
            tick();
        end
        wr_en = 1'b0;

        // Mid-frame reset after the map has been populated
        run(FR / 3);
        do_reset(1);
        write_cell(2, 2, 5);
        run(FR + 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
